// File: rtl/quantum_timer.sv
// -----------------------------------------------------------------------------
// quantum_timer
//
// Preemption timer for a single-core time-sharing CPU. The OS loads a time
// quantum (Set Quantum) while in kernel code, then dispatches a user process
// (Change Context). The timer counts retired user instructions. When the
// quantum is used up it raises a level preemption request (timeout). That
// request stays up until the datapath acknowledges the redirect to the OS
// handler.
//
// A process halt ends the running quantum early and emits a one-cycle
// procDone pulse. A system halt parks the timer in HALTED until reset.
//
// Ports
//   clock               in   system clock, rising-edge active
//   reset               in   synchronous active-high reset
//   setQuantum          in   Set Quantum decode
//   interruptionProcess in   Change Context decode (dispatch to user process)
//   halt[1:0]           in   00 none, 01 process halt, 10 system halt, 11 = 00
//   instrRetire         in   one instruction retired this cycle
//   quantumValue[31:0]  in   quantum to load; only bits [15:0] are used
//   intAck              in   datapath saved user PC and entered OS handler
//   timeout             out  preemption request (level, registered)
//   procDone            out  one-cycle pulse on process halt (registered)
//   halted              out  system halted (level, registered)
//   remaining[15:0]     out  current down-counter value
//   state[2:0]          out  FSM state: IDLE 000, ARMED 001, RUN 010,
//                            EXPIRED 011, HALTED 100
//
// Handshake note: no valid/ready pairs are used here. Each control input is
// a single-cycle decode strobe. A strobe is consumed on the rising edge where
// it is sampled high, if the current state accepts it. Strobes that are not
// accepted are dropped and are not held over. intAck is the only input that
// closes a request: a timeout that is raised stays high until intAck is
// sampled in EXPIRED.
// -----------------------------------------------------------------------------
module quantum_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        setQuantum,
  input  logic        interruptionProcess,
  input  logic [1:0]  halt,
  input  logic        instrRetire,
  input  logic [31:0] quantumValue,
  input  logic        intAck,
  output logic        timeout,
  output logic        procDone,
  output logic        halted,
  output logic [15:0] remaining,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_ARMED   = 3'b001,
    ST_RUN     = 3'b010,
    ST_EXPIRED = 3'b011,
    ST_HALTED  = 3'b100
  } state_e;

  localparam logic [1:0] HALT_PROCESS = 2'b01;
  localparam logic [1:0] HALT_SYSTEM  = 2'b10;

  state_e      state_q, state_d;
  logic [15:0] remaining_q, remaining_d;
  logic        timeout_q, timeout_d;
  logic        proc_done_q, proc_done_d;
  logic        halted_q, halted_d;

  logic [15:0] quantum_load;
  logic        quantum_valid;
  logic        user_running;

  // The upper half of the register-file word is not part of the quantum.
  logic        unused_quantum_upper;
  assign unused_quantum_upper = ^quantumValue[31:16];

  assign quantum_load  = quantumValue[15:0];
  // A zero quantum would expire at once or never. Treat it as no write.
  assign quantum_valid = (quantum_load != 16'd0);
  // A process halt only applies while user code owns the CPU.
  assign user_running  = (state_q == ST_RUN) || (state_q == ST_EXPIRED);

  // ---------------------------------------------------------------------------
  // Next-state logic. The if/else chain encodes the same-cycle priority:
  // system halt, then process halt, then per-state behaviour. Inside RUN,
  // expiry is the only event. Inside EXPIRED, intAck is the only event.
  // Because of that, set/dispatch strobes are never in conflict with expiry
  // or intAck.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    proc_done_d = 1'b0;

    if (state_q == ST_HALTED) begin
      // Terminal until reset; every input is ignored.
      state_d = ST_HALTED;
    end else if (halt == HALT_SYSTEM) begin
      state_d = ST_HALTED;
    end else if ((halt == HALT_PROCESS) && user_running) begin
      state_d     = ST_IDLE;
      remaining_d = 16'd0;
      proc_done_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (setQuantum && quantum_valid) begin
            remaining_d = quantum_load;
            state_d     = ST_ARMED;
          end
        end
        ST_ARMED: begin
          // Dispatch takes precedence over a reload in the same cycle. The
          // quantum already armed is the one the process runs with.
          if (interruptionProcess) begin
            state_d = ST_RUN;
          end else if (setQuantum && quantum_valid) begin
            remaining_d = quantum_load;
          end
        end
        ST_RUN: begin
          // The non-zero guard keeps the counter from ever wrapping.
          if (instrRetire && (remaining_q != 16'd0)) begin
            remaining_d = remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
              state_d = ST_EXPIRED;
            end
          end
        end
        ST_EXPIRED: begin
          if (intAck) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          remaining_d = 16'd0;
        end
      endcase
    end

    // Level outputs follow the state being entered, so they are registered
    // alongside it.
    timeout_d = (state_d == ST_EXPIRED);
    halted_d  = (state_d == ST_HALTED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= 16'd0;
      timeout_q   <= 1'b0;
      proc_done_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      timeout_q   <= timeout_d;
      proc_done_q <= proc_done_d;
      halted_q    <= halted_d;
    end
  end

  assign timeout   = timeout_q;
  assign procDone  = proc_done_q;
  assign halted    = halted_q;
  assign remaining = remaining_q;
  assign state     = state_q;

endmodule

// File: tb/tb_quantum_timer.sv
// -----------------------------------------------------------------------------
// tb_quantum_timer
//
// Self-checking bench for quantum_timer. Directed scenario tasks check the
// DUT against constants. A randomized phase checks it against a behavioural
// model. The observed tuple is {state, remaining, timeout, procDone, halted}.
// -----------------------------------------------------------------------------
module tb_quantum_timer;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic        setQuantum;
  logic        interruptionProcess;
  logic [1:0]  halt;
  logic        instrRetire;
  logic [31:0] quantumValue;
  logic        intAck;
  logic        timeout;
  logic        procDone;
  logic        halted;
  logic [15:0] remaining;
  logic [2:0]  state;

  always #5 clock = ~clock;

  quantum_timer dut (
    .clock               (clock),
    .reset               (reset),
    .setQuantum          (setQuantum),
    .interruptionProcess (interruptionProcess),
    .halt                (halt),
    .instrRetire         (instrRetire),
    .quantumValue        (quantumValue),
    .intAck              (intAck),
    .timeout             (timeout),
    .procDone            (procDone),
    .halted              (halted),
    .remaining           (remaining),
    .state               (state)
  );

  localparam int W = 22;
  localparam logic [2:0] S_IDLE = 3'd0, S_ARMED = 3'd1, S_RUN = 3'd2,
                         S_EXP  = 3'd3, S_HALT  = 3'd4;

  logic [W-1:0] obs;
  assign obs = {state, remaining, timeout, procDone, halted};

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] pk(input logic [2:0] st, input logic [15:0] rem,
                                      input logic to, input logic pd, input logic hl);
    return {st, rem, to, pd, hl};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic sq, input logic ip,
                       input logic [1:0] h, input logic ir,
                       input logic [31:0] qv, input logic ack);
    reset = rst; setQuantum = sq; interruptionProcess = ip; halt = h;
    instrRetire = ir; quantumValue = qv; intAck = ack;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 1'b0);
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 1'b0);
    tick();
    idle_inputs();
  endtask

  // Reset, load quantum qv, dispatch: leaves the DUT in RUN with remaining=qv.
  task automatic arm_and_run(input logic [31:0] qv);
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, qv, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'd0, 1'b0);
    tick();
    idle_inputs();
  endtask

  // ---------------- behavioural reference model ----------------
  // Expected outputs kept as plain variables and updated from the rules:
  // reset wins, HALTED is sticky, system halt, process halt while user code
  // runs, then what each phase accepts.
  logic [2:0]  m_st;
  logic [15:0] m_rem;
  logic        m_pd;

  function automatic void model_step(input logic rst, input logic sq, input logic ip,
                                     input logic [1:0] h, input logic ir,
                                     input logic [31:0] qv, input logic ack);
    logic [15:0] q;
    q    = qv[15:0];
    m_pd = 1'b0;
    if (rst) begin
      m_st = S_IDLE; m_rem = 0;
    end else if (m_st == S_HALT) begin
      // stays halted
    end else if (h == 2'b10) begin
      m_st = S_HALT;
    end else if (h == 2'b01 && (m_st == S_RUN || m_st == S_EXP)) begin
      m_st = S_IDLE; m_rem = 0; m_pd = 1'b1;
    end else if (m_st == S_IDLE) begin
      if (sq && q != 0) begin m_rem = q; m_st = S_ARMED; end
    end else if (m_st == S_ARMED) begin
      if (ip) m_st = S_RUN;
      else if (sq && q != 0) m_rem = q;
    end else if (m_st == S_RUN) begin
      if (ir && m_rem > 0) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) m_st = S_EXP;
      end
    end else if (m_st == S_EXP) begin
      if (ack) m_st = S_IDLE;
    end
  endfunction

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs !== pk(S_IDLE, 16'd0, 0, 0, 0)) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", obs, pk(S_IDLE, 16'd0, 0, 0, 0));
    end
  endtask

  task automatic test_basic_expiry();
    logic [15:0] want_rem[3];
    want_rem[0] = 16'd2; want_rem[1] = 16'd1; want_rem[2] = 16'd0;
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'd3, 1'b0);
    tick();
    n_checks++;
    if (obs !== pk(S_ARMED, 16'd3, 0, 0, 0)) begin
      n_fail++; $display("FAIL expiry_armed: got %h want %h", obs, pk(S_ARMED, 16'd3, 0, 0, 0));
    end
    drive(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'd0, 1'b0);
    tick();
    n_checks++;
    if (obs !== pk(S_RUN, 16'd3, 0, 0, 0)) begin
      n_fail++; $display("FAIL expiry_run: got %h want %h", obs, pk(S_RUN, 16'd3, 0, 0, 0));
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'd0, 1'b0);
      tick();
      n_checks++;
      if (obs !== pk((i == 2) ? S_EXP : S_RUN, want_rem[i], (i == 2), 0, 0)) begin
        n_fail++; $display("FAIL expiry_count%0d: got %h want %h", i, obs,
                           pk((i == 2) ? S_EXP : S_RUN, want_rem[i], (i == 2), 0, 0));
      end
    end
    // timeout holds while waiting for intAck; stray strobes and retires ignored
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 32'd9, 1'b0);
      tick();
      n_checks++;
      if (obs !== pk(S_EXP, 16'd0, 1, 0, 0)) begin
        n_fail++; $display("FAIL expiry_hold%0d: got %h want %h", i, obs, pk(S_EXP, 16'd0, 1, 0, 0));
      end
    end
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 1'b1);
    tick();
    n_checks++;
    if (obs !== pk(S_IDLE, 16'd0, 0, 0, 0)) begin
      n_fail++; $display("FAIL expiry_ack: got %h want %h", obs, pk(S_IDLE, 16'd0, 0, 0, 0));
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    arm_and_run(32'd5);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (obs !== pk(S_RUN, 16'd5, 0, 0, 0)) begin
        n_fail++; $display("FAIL stall_hold%0d: got %h want %h", i, obs, pk(S_RUN, 16'd5, 0, 0, 0));
      end
    end
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'd0, 1'b0);
    tick(); tick();
    idle_inputs();
    tick();
    n_checks++;
    if (obs !== pk(S_RUN, 16'd3, 0, 0, 0)) begin
      n_fail++; $display("FAIL stall_end: got %h want %h", obs, pk(S_RUN, 16'd3, 0, 0, 0));
    end
  endtask

  task automatic test_process_halt();
    arm_and_run(32'd1);
    drive(1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 32'd0, 1'b0);
    tick();
    idle_inputs();
    n_checks++;
    if (obs !== pk(S_IDLE, 16'd0, 0, 1, 0)) begin
      n_fail++; $display("FAIL phalt_pulse: got %h want %h", obs, pk(S_IDLE, 16'd0, 0, 1, 0));
    end
    tick();
    n_checks++;
    if (obs !== pk(S_IDLE, 16'd0, 0, 0, 0)) begin
      n_fail++; $display("FAIL phalt_after: got %h want %h", obs, pk(S_IDLE, 16'd0, 0, 0, 0));
    end
    // process halt ignored in IDLE and ARMED
    drive(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 32'd0, 1'b0);
    tick();
    n_checks++;
    if (obs !== pk(S_IDLE, 16'd0, 0, 0, 0)) begin
      n_fail++; $display("FAIL phalt_idle: got %h want %h", obs, pk(S_IDLE, 16'd0, 0, 0, 0));
    end
    drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'd4, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 32'd0, 1'b1);
    tick();
    n_checks++;
    if (obs !== pk(S_ARMED, 16'd4, 0, 0, 0)) begin
      n_fail++; $display("FAIL phalt_armed: got %h want %h", obs, pk(S_ARMED, 16'd4, 0, 0, 0));
    end
    idle_inputs();
  endtask

  task automatic test_zero_quantum();
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0001_0000, 1'b0);
    tick();
    n_checks++;
    if (obs !== pk(S_IDLE, 16'd0, 0, 0, 0)) begin
      n_fail++; $display("FAIL zeroq_idle: got %h want %h", obs, pk(S_IDLE, 16'd0, 0, 0, 0));
    end
    // upper bits ignored on a valid load; zero write ignored in ARMED
    drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'hABCD_0006, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'hFFFF_0000, 1'b0);
    tick();
    n_checks++;
    if (obs !== pk(S_ARMED, 16'd6, 0, 0, 0)) begin
      n_fail++; $display("FAIL zeroq_armed: got %h want %h", obs, pk(S_ARMED, 16'd6, 0, 0, 0));
    end
    drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'd2, 1'b0);
    tick();
    n_checks++;
    if (obs !== pk(S_ARMED, 16'd2, 0, 0, 0)) begin
      n_fail++; $display("FAIL reload_armed: got %h want %h", obs, pk(S_ARMED, 16'd2, 0, 0, 0));
    end
    idle_inputs();
  endtask

  task automatic test_system_halt();
    arm_and_run(32'd1);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 1'b0);
    tick();
    n_checks++;
    if (obs !== pk(S_HALT, 16'd0, 0, 0, 1)) begin
      n_fail++; $display("FAIL shalt_enter: got %h want %h", obs, pk(S_HALT, 16'd0, 0, 0, 1));
    end
    drive(1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 32'd8, 1'b1);
    tick(); tick();
    n_checks++;
    if (obs !== pk(S_HALT, 16'd0, 0, 0, 1)) begin
      n_fail++; $display("FAIL shalt_sticky: got %h want %h", obs, pk(S_HALT, 16'd0, 0, 0, 1));
    end
    // reset beats every other input
    drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 32'd8, 1'b1);
    tick();
    idle_inputs();
    n_checks++;
    if (obs !== pk(S_IDLE, 16'd0, 0, 0, 0)) begin
      n_fail++; $display("FAIL shalt_reset: got %h want %h", obs, pk(S_IDLE, 16'd0, 0, 0, 0));
    end
  endtask

  task automatic test_reset_mid_run();
    arm_and_run(32'd9);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'd0, 1'b0);
    tick(); tick();
    n_checks++;
    if (obs !== pk(S_RUN, 16'd7, 0, 0, 0)) begin
      n_fail++; $display("FAIL midrun_pre: got %h want %h", obs, pk(S_RUN, 16'd7, 0, 0, 0));
    end
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'd0, 1'b0);
    tick();
    idle_inputs();
    n_checks++;
    if (obs !== pk(S_IDLE, 16'd0, 0, 0, 0)) begin
      n_fail++; $display("FAIL midrun_reset: got %h want %h", obs, pk(S_IDLE, 16'd0, 0, 0, 0));
    end
  endtask

  task automatic test_random();
    logic        rst, sq, ip, ir, ack;
    logic [1:0]  h;
    logic [31:0] qv;
    logic [W-1:0] exp_v;
    m_st = S_IDLE; m_rem = 0; m_pd = 0;
    for (int i = 0; i < 600; i++) begin
      rst = (i == 0) || ($urandom_range(0, 79) == 0);
      sq  = ($urandom_range(0, 3) == 0);
      ip  = ($urandom_range(0, 3) == 0);
      ir  = ($urandom_range(0, 1) == 1);
      ack = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 59))
        0:       h = 2'b10;
        1, 2, 3: h = 2'b01;
        4, 5:    h = 2'b11;
        default: h = 2'b00;
      endcase
      qv = {16'($urandom), 16'($urandom_range(0, 6))};
      drive(rst, sq, ip, h, ir, qv, ack);
      model_step(rst, sq, ip, h, ir, qv, ack);
      exp_q.push_back(pk(m_st, m_rem, (m_st == S_EXP), m_pd, (m_st == S_HALT)));
      tick();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL random_cycle%0d: got %h want %h", i, obs, exp_v);
      end
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_basic_expiry();
    test_stall();
    test_process_halt();
    test_zero_quantum();
    test_system_halt();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
